// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared APB FSM states, register stride and error reason codes
package reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apbState_e;

    localparam int REG_STRIDE = 4;
    localparam int OFFS_W     = $clog2(REG_STRIDE);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_READONLY = 2'd3;

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational APB address to register index / error decode
module apb_addr_decode
    import reg_pkg::*;
#(
    parameter int                  ADDR_W   = 12,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic [ADDR_W-1:0]        paddr,
    input  logic                     pwrite,
    output logic [ADDR_W-OFFS_W-1:0] idx,
    output logic [1:0]               errCode
);

    localparam int IDX_W = ADDR_W - OFFS_W;

    logic inRange;
    logic roHit;

    always_comb begin
        idx     = paddr[ADDR_W-1:OFFS_W];
        inRange = 1'b0;
        roHit   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                inRange = 1'b1;
                roHit   = RO_MASK[i];
            end
        end
        if (paddr[OFFS_W-1:0] != '0) begin
            errCode = ERR_MISALIGN;
        end else if (!inRange) begin
            errCode = ERR_RANGE;
        end else if (pwrite && roHit) begin
            errCode = ERR_READONLY;
        end else begin
            errCode = ERR_NONE;
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB3 slave front-end: FSM, wait states, write strobes, readback mux
module apb_reg_slave
    import reg_pkg::*;
#(
    parameter int                  ADDR_W      = 12,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  WAIT_CYCLES = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    output logic                         pready,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pslverr,
    output logic [NUM_REGS-1:0]          wr_en,
    output logic [DATA_W-1:0]            wr_data,
    input  logic [NUM_REGS*DATA_W-1:0]   rd_data
);

    localparam int IDX_W = ADDR_W - OFFS_W;

    apbState_e          state, stateNext;
    logic [3:0]         waitCnt, waitCntNext;
    logic [IDX_W-1:0]   decIdx, idxQ, curIdx;
    logic [1:0]         decCode;
    logic               decErr, errQ, writeQ, curErr, curWrite;
    logic               latchSetup, enterReady;
    logic [NUM_REGS-1:0] wrEnNext;
    logic [DATA_W-1:0]  rdSel;

    apb_addr_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) uDecode (
        .paddr   (paddr),
        .pwrite  (pwrite),
        .idx     (decIdx),
        .errCode (decCode)
    );

    assign decErr = (decCode != ERR_NONE);

    // With no wait states the READY edge is the SETUP edge, so the live decode is used there.
    assign curIdx   = (state == IDLE) ? decIdx : idxQ;
    assign curErr   = (state == IDLE) ? decErr : errQ;
    assign curWrite = (state == IDLE) ? pwrite : writeQ;

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        latchSetup  = 1'b0;
        enterReady  = 1'b0;
        case (state)
            IDLE: begin
                waitCntNext = 4'd0;
                if (psel && !penable) begin
                    latchSetup = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        stateNext  = READY;
                        enterReady = 1'b1;
                    end else begin
                        stateNext   = WAIT;
                        waitCntNext = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    stateNext   = IDLE;
                    waitCntNext = 4'd0;
                end else if (waitCnt == 4'(WAIT_CYCLES)) begin
                    stateNext  = READY;
                    enterReady = 1'b1;
                end else if (waitCnt != 4'hF) begin
                    waitCntNext = waitCnt + 4'd1;
                end
            end
            READY: begin
                stateNext   = IDLE;
                waitCntNext = 4'd0;
            end
            default: begin
                stateNext   = IDLE;
                waitCntNext = 4'd0;
            end
        endcase
    end

    always_comb begin
        rdSel    = '0;
        wrEnNext = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (curIdx == IDX_W'(i)) begin
                rdSel       = rd_data[i*DATA_W +: DATA_W];
                wrEnNext[i] = curWrite && !curErr;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idxQ    <= '0;
            writeQ  <= 1'b0;
            errQ    <= 1'b0;
            wr_data <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            wr_en   <= '0;
            prdata  <= '0;
        end else begin
            if (latchSetup) begin
                idxQ    <= decIdx;
                writeQ  <= pwrite;
                errQ    <= decErr;
                wr_data <= pwdata;
            end
            pready  <= enterReady;
            pslverr <= enterReady && curErr;
            wr_en   <= enterReady ? wrEnNext : '0;
            if (enterReady && !curWrite) begin
                prdata <= curErr ? '0 : rdSel;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - bench for apb_reg_slave with three parameterisations and looped-back cells
module tb_apb_reg_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;

    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] prdata  [3];
    logic [31:0] wrData  [3];
    logic [7:0]  wrEn    [3];
    logic [255:0] rdData [3];

    logic [31:0] cells  [3][8];
    logic [31:0] seed   [3][8];
    logic [31:0] refMem [3][8];
    logic        loadCells;

    int          refWait [3] = '{0, 3, 5};
    logic [7:0]  refRo   [3] = '{8'h00, 8'h04, 8'h81};

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lastReadyCyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    apb_reg_slave #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .RO_MASK(8'h00), .WAIT_CYCLES(0)) dutA (
        .clock(clock), .reset(reset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]),
        .pslverr(pslverr[0]), .wr_en(wrEn[0]), .wr_data(wrData[0]), .rd_data(rdData[0]));

    apb_reg_slave #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .RO_MASK(8'h04), .WAIT_CYCLES(3)) dutB (
        .clock(clock), .reset(reset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]),
        .pslverr(pslverr[1]), .wr_en(wrEn[1]), .wr_data(wrData[1]), .rd_data(rdData[1]));

    apb_reg_slave #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .RO_MASK(8'h81), .WAIT_CYCLES(5)) dutC (
        .clock(clock), .reset(reset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]),
        .pslverr(pslverr[2]), .wr_en(wrEn[2]), .wr_data(wrData[2]), .rd_data(rdData[2]));

    // Register cells downstream of each slave: capture wr_data on the edge ending READY.
    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (loadCells) cells[k][i] <= seed[k][i];
                else if (wrEn[k][i]) cells[k][i] <= wrData[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rdData[k] = '0;
            for (int i = 0; i < 8; i++) rdData[k][i*32 +: 32] = cells[k][i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer on slave k; returns one tick after the edge that ends READY.
    task automatic xfer(input int k, input logic wr, input logic [11:0] addr, input logic [31:0] data);
        int          idx;
        logic        expErr;
        logic [7:0]  expWe;
        logic [31:0] expRd;
        bit          seen;
        int          c;
        idx    = int'(addr >> 2);
        expErr = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && refRo[k][idx[2:0]]);
        expWe  = (wr && !expErr) ? 8'(1 << idx) : 8'h00;
        expRd  = expErr ? 32'h0 : refMem[k][idx[2:0]];
        psel    = 3'b000;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clock); #1;
        penable = 1'b1;
        seen = 1'b0;
        for (c = 1; c <= 20 && !seen; c++) begin
            @(negedge clock);
            if (pready[k]) begin
                seen = 1'b1;
                lastReadyCyc = cyc;
                check($sformatf("latency_k%0d", k), 32'(c), 32'(refWait[k] + 1));
                check($sformatf("pslverr_k%0d_a%0h", k, addr), 32'(pslverr[k]), 32'(expErr));
                check($sformatf("wr_en_k%0d_a%0h", k, addr), 32'(wrEn[k]), 32'(expWe));
                if (wr) check($sformatf("wr_data_k%0d", k), wrData[k], data);
                else    check($sformatf("prdata_k%0d_a%0h", k, addr), prdata[k], expRd);
            end else if (wrEn[k] != 8'h00 || pslverr[k]) begin
                check($sformatf("early_strobe_k%0d", k), 32'({wrEn[k], pslverr[k]}), 32'h0);
            end
            @(posedge clock); #1;
        end
        check($sformatf("pready_seen_k%0d", k), 32'(seen), 32'h1);
        if (wr && !expErr) refMem[k][idx[2:0]] = data;
    endtask

    task automatic idle(input int n);
        psel    = 3'b000;
        penable = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int          r1;
        bit          strobe;
        int          k;
        int          ri;
        logic [11:0] a;

        reset     = 1'b1;
        psel      = 3'b000;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        loadCells = 1'b1;
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < 8; i++) seed[kk][i] = $urandom | 32'h1;
        end
        seed[1][1] = 32'h12345678;
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < 8; i++) refMem[kk][i] = seed[kk][i];
        end
        repeat (2) @(posedge clock); #1;
        loadCells = 1'b0;

        for (int kk = 0; kk < 3; kk++) begin
            check($sformatf("rst_pready_k%0d", kk), 32'(pready[kk]), 32'h0);
            check($sformatf("rst_pslverr_k%0d", kk), 32'(pslverr[kk]), 32'h0);
            check($sformatf("rst_prdata_k%0d", kk), prdata[kk], 32'h0);
            check($sformatf("rst_wr_en_k%0d", kk), 32'(wrEn[kk]), 32'h0);
            check($sformatf("rst_wr_data_k%0d", kk), wrData[kk], 32'h0);
        end
        reset = 1'b0;
        @(posedge clock); #1;

        xfer(0, 1'b1, 12'h008, 32'hDEADBEEF);
        idle(1);
        xfer(1, 1'b0, 12'h004, 32'h0);
        idle(1);
        xfer(0, 1'b1, 12'h020, 32'h11111111);
        xfer(0, 1'b1, 12'h006, 32'h22222222);
        xfer(1, 1'b1, 12'h008, 32'h33333333);
        xfer(1, 1'b0, 12'h008, 32'h0);
        xfer(0, 1'b0, 12'h020, 32'h0);
        idle(2);

        xfer(0, 1'b1, 12'h000, 32'hA5A5_0F0F);
        r1 = lastReadyCyc;
        xfer(0, 1'b0, 12'h000, 32'h0);
        check("b2b_pready_spacing", 32'(lastReadyCyc - r1), 32'd2);
        idle(1);

        xfer(2, 1'b0, 12'h00C, 32'h0);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h00C;
        pwdata  = 32'hCAFEF00D;
        @(posedge clock); #1;
        penable = 1'b1;
        @(posedge clock); #1;
        check("wr_data_latched_before_reset", wrData[2], 32'hCAFEF00D);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pready", 32'(pready[2]), 32'h0);
        check("async_rst_pslverr", 32'(pslverr[2]), 32'h0);
        check("async_rst_prdata", prdata[2], 32'h0);
        check("async_rst_wr_en", 32'(wrEn[2]), 32'h0);
        check("async_rst_wr_data", wrData[2], 32'h0);
        @(posedge clock); #1;
        reset   = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        strobe  = 1'b0;
        repeat (10) begin
            @(negedge clock);
            strobe = strobe | (wrEn[2] != 8'h00) | pready[2];
        end
        check("no_strobe_after_reset", 32'(strobe), 32'h0);
        @(posedge clock); #1;
        xfer(2, 1'b0, 12'h00C, 32'h0);
        xfer(2, 1'b1, 12'h010, 32'h0BAD_CAFE);
        xfer(2, 1'b1, 12'h01C, 32'h7777_7777);
        idle(1);

        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h014;
        pwdata  = 32'hFEED_FACE;
        @(posedge clock); #1;
        penable = 1'b1;
        @(posedge clock); #1;
        psel    = 3'b000;
        penable = 1'b0;
        strobe  = 1'b0;
        repeat (8) begin
            @(negedge clock);
            strobe = strobe | (wrEn[1] != 8'h00) | pready[1];
        end
        check("abort_no_strobe", 32'(strobe), 32'h0);
        @(posedge clock); #1;
        xfer(1, 1'b0, 12'h014, 32'h0);

        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 2);
            ri = $urandom_range(0, 9);
            a  = 12'(ri * 4);
            if ($urandom_range(0, 5) == 0) a = a + 12'($urandom_range(1, 3));
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < 8; i++) xfer(kk, 1'b0, 12'(i * 4), 32'h0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
